data_mem_responder: RTL and testbench

- Responder for the core's data-memory interface (data_address, wdata, wstrobe, wen, ren, rdata).
- Provides word-organised RAM with byte-strobe writes and a small MMIO window.
- MMIO window holds a free-running cycle counter, a console output FIFO with a valid/ready drain port, and a sticky error register.
- Reads are zero-latency because the core consumes rdata in the same cycle it asserts ren. Writes commit on the rising clk edge.

---
 rtl/data_mem_pkg.sv | 14 +
 rtl/console_fifo.sv | 52 +++++
 rtl/data_mem_responder.sv | 90 +++++++++
 tb/tb_data_mem_responder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared MMIO map, error bit indices and STATUS layout for the data-memory responder.
package data_mem_pkg;
    localparam logic [3:0] OFF_CYCLE = 4'h0;
    localparam logic [3:0] OFF_CONS  = 4'h4;
    localparam logic [3:0] OFF_STAT  = 4'h8;
    localparam logic [3:0] OFF_ERR   = 4'hC;

    localparam int ERR_UNMAPPED = 0;
    localparam int ERR_OVF      = 1;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_CNT   = 2;
endpackage

// File: rtl/console_fifo.sv
// console_fifo: synchronous FIFO with a combinational head; a push into a full FIFO is accepted
// only when a pop frees the slot in the same cycle.
module console_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        full    = cnt_q == CW'(DEPTH);
        empty   = cnt_q == '0;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        head    = empty ? '0 : mem_q[rd_q];
        count   = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: zero-latency-read data memory with byte-strobe RAM and an MMIO window
// holding a cycle counter, console FIFO and sticky error register.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_address,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrobe,
    input  logic        wen,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [1:0]  err
);
    localparam int RAM_AW = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram_q [DEPTH_WORDS];
    logic [31:0]       cycle_q, cycle_d;
    logic [1:0]        err_q, err_d, err_set, err_clr;
    logic              is_ram, is_mmio, push, full, empty;
    logic [3:0]        off;
    logic [RAM_AW-1:0] widx;
    logic [CNT_W-1:0]  count;
    logic [31:0]       stat;

    console_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (wdata[7:0]),
        .pop       (tx_ready),
        .head      (tx_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        is_ram  = data_address < DEPTH_WORDS * 4;
        is_mmio = data_address >= MMIO_BASE && data_address <= MMIO_BASE + 32'hC;
        off     = {data_address[3:2], 2'b00};
        widx    = data_address[RAM_AW+1:2];
        push    = wen && is_mmio && off == OFF_CONS && wstrobe[0];
        err_set = '0;
        err_set[ERR_UNMAPPED] = (wen || ren) && !is_ram && !is_mmio;
        // full implies non-empty, so tx_ready alone means a slot frees this cycle
        err_set[ERR_OVF] = push && full && !tx_ready;
        err_clr = (wen && is_mmio && off == OFF_ERR && wstrobe[0]) ? wdata[1:0] : 2'b00;
        err_d   = (err_q & ~err_clr) | err_set;
        cycle_d = cycle_q + 32'd1;
        stat    = (32'(count) << STAT_CNT) | (32'(empty) << STAT_EMPTY) | (32'(full) << STAT_FULL);
        tx_valid = !empty;
        err      = err_q;
    end

    always_comb begin
        rdata = '0;
        if (ren && is_ram) rdata = ram_q[widx];
        else if (ren && is_mmio)
            rdata = off == OFF_CYCLE ? cycle_q :
                    off == OFF_STAT  ? stat :
                    off == OFF_ERR   ? {30'b0, err_q} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
            err_q   <= '0;
        end else begin
            cycle_q <= cycle_d;
            err_q   <= err_d;
        end
    end

    // RAM is not reset: writes presented during reset still land
    always_ff @(posedge clk) begin
        if (wen && is_ram)
            for (int i = 0; i < 4; i++)
                if (wstrobe[i]) ram_q[widx][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed scenarios plus randomized traffic checked against a
// queue/array reference model of the memory map.
module tb_data_mem_responder;
    localparam logic [31:0] MB = 32'h8000_0000;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] data_address = '0, wdata = '0;
    logic [3:0]  wstrobe = '0;
    logic        wen = 1'b0, ren = 1'b0, tx_ready = 1'b0;
    logic [31:0] rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [1:0]  err;
    int          errors = 0, checks = 0;

    logic [31:0] m_ram [int];
    logic [7:0]  m_q [$];
    logic [1:0]  m_err = '0;
    logic [31:0] m_ticks = '0, m_adj = '0;

    data_mem_responder dut (
        .clk(clk), .rst(rst), .data_address(data_address), .wdata(wdata), .wstrobe(wstrobe),
        .wen(wen), .ren(ren), .rdata(rdata), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic logic [31:0] exp_rd(input logic [31:0] a, input logic r);
        if (!r) return '0;
        if (a < 32'h1000) return m_ram.exists(int'(a[11:2])) ? m_ram[int'(a[11:2])] : 'x;
        if (a >= MB && a <= MB + 32'hC) begin
            if (a[3:2] == 2'd0) return m_ticks + m_adj;
            if (a[3:2] == 2'd2) return {27'b0, 3'(m_q.size()), m_q.size() == 0, m_q.size() == 4};
            if (a[3:2] == 2'd3) return {30'b0, m_err};
        end
        return '0;
    endfunction

    // Applies the memory-map rules to the inputs about to be sampled by the next edge.
    task automatic model_tick();
        logic [31:0] w;
        logic [1:0]  set, clr;
        logic        mm;
        int          idx;
        idx = int'(data_address[11:2]);
        if (wen && data_address < 32'h1000) begin
            w = m_ram.exists(idx) ? m_ram[idx] : 'x;
            for (int i = 0; i < 4; i++) if (wstrobe[i]) w[8*i +: 8] = wdata[8*i +: 8];
            m_ram[idx] = w;
        end
        if (rst) begin
            m_q.delete();
            m_err = '0;
            m_ticks = '0;
        end else begin
            mm = data_address >= MB && data_address <= MB + 32'hC;
            set = '0;
            set[0] = (wen || ren) && data_address >= 32'h1000 && !mm;
            if (m_q.size() > 0 && tx_ready) void'(m_q.pop_front());
            if (wen && mm && data_address[3:2] == 2'd1 && wstrobe[0]) begin
                if (m_q.size() < 4) m_q.push_back(wdata[7:0]);
                else set[1] = 1'b1;
            end
            clr = (wen && mm && data_address[3:2] == 2'd3 && wstrobe[0]) ? wdata[1:0] : 2'b00;
            m_err = (m_err & ~clr) | set;
            m_ticks = m_ticks + 32'd1;
        end
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
        wstrobe = '0;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic w, input logic r);
        data_address = a;
        wdata = d;
        wstrobe = s;
        wen = w;
        ren = r;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        put(a, d, s, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        put(MB, 0, 0, 1'b0, 1'b1);
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", err); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_cycle: got %h want 0", rdata); end
        rst = 1'b0;
        ren = 1'b0;
    endtask

    task automatic test_cycle();
        repeat (100) step();
        put(MB, 0, 0, 1'b0, 1'b1);
        #1;
        checks++; if (rdata !== 32'd100) begin errors++; $display("FAIL cycle_100: got %0d want 100", rdata); end
        force dut.cycle_q = 32'hFFFF_FFFF;
        m_adj = 32'hFFFF_FFFF - m_ticks;
        #1;
        release dut.cycle_q;
        #1;
        checks++; if (rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_max: got %h want ffffffff", rdata); end
        step();
        put(MB, 32'h1234, 4'hF, 1'b1, 1'b1);
        #1;
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL cycle_wrap: got %h want 0", rdata); end
        step();
        put(MB, 0, 0, 1'b0, 1'b1);
        #1;
        checks++; if (rdata !== 32'd1) begin errors++; $display("FAIL cycle_write_ignored: got %h want 1", rdata); end
    endtask

    task automatic test_strobe();
        wr(32'h10, 32'hAABB_CCDD, 4'hF);
        wr(32'h10, 32'h1122_3344, 4'b0101);
        put(32'h10, 0, 0, 1'b0, 1'b1);
        #1;
        checks++; if (rdata !== 32'hAA22_CC44) begin errors++; $display("FAIL strobe_merge: got %h want aa22cc44", rdata); end
        ren = 1'b0;
        #1;
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL ren_low_zero: got %h want 0", rdata); end
        wr(32'h14, 32'h0102_0304, 4'hF);
        put(32'h14, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1);
        #1;
        checks++; if (rdata !== 32'h0102_0304) begin errors++; $display("FAIL raw_old: got %h want 01020304", rdata); end
        step();
        put(32'h14, 0, 0, 1'b0, 1'b1);
        #1;
        checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL raw_new: got %h want deadbeef", rdata); end
    endtask

    task automatic test_backpressure();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(MB + 32'h4, 32'h41 + i, 4'h1);
        put(MB + 32'h8, 0, 0, 1'b0, 1'b1);
        #1;
        checks++; if (rdata !== 32'h11) begin errors++; $display("FAIL bp_status: got %h want 11", rdata); end
        checks++; if (err !== 2'b10) begin errors++; $display("FAIL bp_err: got %b want 10", err); end
        data_address = MB + 32'hC;
        #1;
        checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL bp_err_reg: got %h want 2", rdata); end
        ren = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
                errors++; $display("FAIL bp_drain%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(8'h41 + i));
            end
            step();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", tx_valid); end
        tx_ready = 1'b0;
        wr(MB + 32'hC, 32'h2, 4'h1);
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL bp_w1c: got %b want 00", err); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp [4];
        exp = '{8'h62, 8'h63, 8'h64, 8'h5A};
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(MB + 32'h4, 32'h61 + i, 4'h1);
        tx_ready = 1'b1;
        wr(MB + 32'h4, 32'h5A, 4'h1);
        tx_ready = 1'b0;
        put(MB + 32'h8, 0, 0, 1'b0, 1'b1);
        #1;
        checks++; if (rdata !== 32'h11) begin errors++; $display("FAIL ppf_status: got %h want 11", rdata); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL ppf_err: got %b want 00", err); end
        ren = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
                errors++; $display("FAIL ppf_drain%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp[i]);
            end
            step();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ppf_empty: got %b want 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_unmapped_w1c();
        put(32'h4000_0000, 0, 0, 1'b0, 1'b1);
        #1;
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL unm_rdata: got %h want 0", rdata); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL unm_err_before: got %b want 00", err); end
        step();
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL unm_err_set: got %b want 01", err); end
        wr(MB + 32'hC, 32'h1, 4'h0);
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL w1c_no_strobe: got %b want 01", err); end
        wr(MB + 32'hC, 32'h1, 4'h1);
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL w1c_clear: got %b want 00", err); end
        wr(32'h9000_0000, 32'h55, 4'hF);
        for (int i = 0; i < 5; i++) wr(MB + 32'h4, 32'h30 + i, 4'h1);
        checks++; if (err !== 2'b11) begin errors++; $display("FAIL unm_both: got %b want 11", err); end
        wr(MB + 32'hC, 32'h1, 4'h1);
        checks++; if (err !== 2'b10) begin errors++; $display("FAIL w1c_selective: got %b want 10", err); end
        wr(MB + 32'hC, 32'h3, 4'h1);
        tx_ready = 1'b1;
        repeat (4) step();
        tx_ready = 1'b0;
        checks++; if (err !== 2'b00 || tx_valid !== 1'b0) begin errors++; $display("FAIL unm_cleanup: got err=%b v=%b want 00 0", err, tx_valid); end
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(MB + 32'h4, 32'h71 + i, 4'h1);
        put(32'h4000_0000, 0, 0, 1'b0, 1'b1);
        step();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        put(MB + 32'h8, 0, 0, 1'b0, 1'b1);
        #1;
        checks++; if (rdata !== 32'hC || err !== 2'b11 || tx_data !== 8'h72) begin
            errors++; $display("FAIL rm_pre: got stat=%h err=%b d=%h want c 11 72", rdata, err, tx_data);
        end
        rst = 1'b1;
        m_adj = '0;
        put(32'h18, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0);
        step();
        rst = 1'b0;
        checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL rm_tx: got v=%b d=%h want 0 00", tx_valid, tx_data); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL rm_err: got %b want 00", err); end
        put(MB + 32'h8, 0, 0, 1'b0, 1'b1);
        #1;
        checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL rm_status: got %h want 2", rdata); end
        data_address = 32'h10;
        #1;
        checks++; if (rdata !== 32'hAA22_CC44) begin errors++; $display("FAIL rm_ram_kept: got %h want aa22cc44", rdata); end
        data_address = 32'h18;
        #1;
        checks++; if (rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rm_ram_in_reset: got %h want cafef00d", rdata); end
        data_address = MB;
        #1;
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rm_cycle: got %h want 0", rdata); end
        rst = 1'b1;
        put(MB + 32'h4, 32'h99, 4'h1, 1'b1, 1'b0);
        step();
        rst = 1'b0;
        step();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rm_push_in_reset: got %b want 0", tx_valid); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          sel;
        for (int w = 0; w < 16; w++) wr(32'h100 + 32'(4 * w), $urandom, 4'hF);
        for (int n = 0; n < 500; n++) begin
            sel = $urandom_range(0, 9);
            a = sel < 5 ? 32'h100 + $urandom_range(0, 63) :
                sel < 8 ? MB + $urandom_range(0, 15) :
                sel == 8 ? 32'h4000_0000 + $urandom_range(0, 255) : MB + 32'h10 + $urandom_range(0, 255);
            put(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0);
            tx_ready = $urandom_range(0, 2) != 0;
            #1;
            checks++; if (rdata !== exp_rd(a, ren)) begin errors++; $display("FAIL rnd_rdata@%0d: addr=%h got %h want %h", n, a, rdata, exp_rd(a, ren)); end
            checks++; if (tx_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", n, tx_valid, m_q.size() != 0); end
            checks++; if (tx_data !== (m_q.size() != 0 ? m_q[0] : 8'h00)) begin errors++; $display("FAIL rnd_data@%0d: got %h want %h", n, tx_data, m_q.size() != 0 ? m_q[0] : 8'h00); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err@%0d: got %b want %b", n, err, m_err); end
            step();
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cycle();
        test_strobe();
        test_backpressure();
        test_push_pop_full();
        test_unmapped_w1c();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
